controlador_escrita_registradores: RTL and testbench
====================================================

Name: controlador_escrita_registradores

Overview:
- Writer side of the 32x32 register bank: collects results from the ALU and load/memory paths and drives the bank's write port (reg_escrita, endereco_regd, dado_escrita).
- Buffers results in a small in-order FIFO and sign/zero-extends load data.
- Drains one write per cycle.
- Exposes pending-write flags for two source registers so decode can stall on RAW hazards.

Parameters:
- PROFUNDIDADE, 4, FIFO entries; power of two, at least 2.
- LARG_OCUP, $clog2(PROFUNDIDADE)+1, width of the occupancy counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
- alu_valido  input  1  ALU result offered.
- alu_pronto  output  1  ALU result accepted this cycle when high together with alu_valido.
- alu_rd  input  5  ALU destination register.
- alu_dado  input  32  ALU result.
- mem_valido  input  1  load result offered.
- mem_pronto  output  1  load result accepted this cycle when high together with mem_valido.
- mem_rd  input  5  load destination register.
- mem_dado  input  32  raw load word, already shifted so the byte or half is at bit 0.
- mem_funct3  input  3  load type.
- reg_escrita  output  1  bank write enable.
- endereco_regd  output  5  bank destination address.
- dado_escrita  output  32  bank write data.
- consulta_reg1  input  5  decode source 1 to check.
- consulta_reg2  input  5  decode source 2 to check.
- pendente1  output  1  a queued write targets consulta_reg1.
- pendente2  output  1  a queued write targets consulta_reg2.
- ocupacao  output  LARG_OCUP  number of queued entries.
- vazio  output  1  ocupacao == 0.

Behaviour:
- Reset (reset_n=0 at posedge):
  - Pointers and ocupacao go to 0 and all entries are invalidated.
  - reg_escrita=0, endereco_regd=0, dado_escrita=0, pendente1/2=0, vazio=1.
  - Reset wins over a simultaneous push or pop; in-flight results are discarded.
- Write port:
  - Driven combinationally from the FIFO head.
  - When not empty: reg_escrita=1 with the head's rd and data. The head is popped at that posedge; the bank always accepts.
  - When empty: reg_escrita=0, endereco_regd=0, dado_escrita=0.
- Latency: a result accepted at edge N appears on the write port during cycle N+1 and lands in the bank at edge N+1 (empty-FIFO case).
- Ready rules (combinational, evaluated against free slots after this cycle's pop):
  - livres = PROFUNDIDADE - ocupacao + (vazio ? 0 : 1).
  - mem_pronto = (livres >= 1).
  - alu_pronto = (livres >= (mem_valido ? 2 : 1)). Memory has priority.
- Simultaneous push: when both are accepted, the load result is enqueued before the ALU result; two pushes in one cycle are allowed.
- Writes to x0: a result with rd=0 is accepted (ready as normal) but not enqueued. It does not consume a slot, but it still counts against livres for the ready computation.
- Load formatting, applied at enqueue:
  - 000 LB: sign-extend [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: unchanged.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - Any other code: unchanged.
- Occupancy: ocupacao(next) = ocupacao + pushes - pop. It never exceeds PROFUNDIDADE and never underflows.
- Wrap-around: read and write pointers wrap modulo PROFUNDIDADE.
- Pending flags:
  - pendenteK = 1 iff some valid queued entry has rd == consulta_regK and consulta_regK != 0.
  - The flags reflect queue contents only (registered state), not same-cycle inputs.
- Ordering: entries drain strictly in enqueue order. Two queued writes to the same rd both reach the bank, oldest first.

Optional Feature:
- Macro: ESCRITA_ENCAMINHAMENTO_EN.
- When defined, two extra outputs dado_encaminhado1 and dado_encaminhado2 (32 bits each) are added. Each carries the data of the youngest queued entry whose rd matches consulta_regK, or 0 when pendenteK=0.
- Decode may then use forwarded data instead of stalling.
- When not defined: the ports do not exist, no forwarding logic is built, and all other behaviour is unchanged.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles -> reg_escrita=0, vazio=1, ocupacao=0, both ready flags 1.
- Single ALU write: alu_rd=5, alu_dado=0x1234 for one cycle -> next cycle reg_escrita=1, endereco_regd=5, dado_escrita=0x1234; vazio=1 again in the cycle after.
- Load extension: mem_funct3=000, mem_dado=0x000000F0, rd=7 -> dado_escrita=0xFFFFFFF0. Repeat with funct3=100 -> dado_escrita=0x000000F0. Repeat with funct3=101, mem_dado=0x00008001 -> 0x00008001.
- Simultaneous push and ordering: both valid (mem rd=3 with 0xA, alu rd=4 with 0xB) -> writes appear on consecutive cycles, rd=3 then rd=4.
- Full/backpressure: both sources valid every cycle with rd≠0 -> ocupacao saturates at 4; alu_pronto=0 while mem_valido=1 and livres=1; no entry lost or duplicated (scoreboard check).
- x0 and pending flags:
  - alu_rd=0 -> accepted, no bank write.
  - Queue rd=9 behind a stall, set consulta_reg1=9 -> pendente1=1 until that entry drains.
  - consulta_reg2=0 -> pendente2=0.
  - With ESCRITA_ENCAMINHAMENTO_EN defined: two queued writes to rd=9 (0x1 then 0x2) -> dado_encaminhado1=0x2.

Source files
------------

// File: rtl/controlador_escrita_registradores.sv
// Register-bank writer: in-order result FIFO with load extension and RAW flags.
// Define ESCRITA_ENCAMINHAMENTO_EN to add the dado_encaminhado1/2 forwarding ports.
module controlador_escrita_registradores #(
   parameter int PROFUNDIDADE = 4,
   parameter int LARG_OCUP    = $clog2(PROFUNDIDADE) + 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 alu_valido,
   output logic                 alu_pronto,
   input  logic [4:0]           alu_rd,
   input  logic [31:0]          alu_dado,
   input  logic                 mem_valido,
   output logic                 mem_pronto,
   input  logic [4:0]           mem_rd,
   input  logic [31:0]          mem_dado,
   input  logic [2:0]           mem_funct3,
   output logic                 reg_escrita,
   output logic [4:0]           endereco_regd,
   output logic [31:0]          dado_escrita,
   input  logic [4:0]           consulta_reg1,
   input  logic [4:0]           consulta_reg2,
   output logic                 pendente1,
   output logic                 pendente2,
   output logic [LARG_OCUP-1:0] ocupacao,
   output logic                 vazio
`ifdef ESCRITA_ENCAMINHAMENTO_EN
   ,
   output logic [31:0]          dado_encaminhado1,
   output logic [31:0]          dado_encaminhado2
`endif
);

   localparam int LARG_PTR = $clog2(PROFUNDIDADE);
   localparam logic [LARG_OCUP:0] P_EXT = (LARG_OCUP+1)'(PROFUNDIDADE);

   logic [4:0]              r_rd   [PROFUNDIDADE];
   logic [31:0]             r_dado [PROFUNDIDADE];
   logic [PROFUNDIDADE-1:0] r_val;
   logic [LARG_PTR-1:0]     r_rp;
   logic [LARG_PTR-1:0]     r_wp;
   logic [LARG_OCUP-1:0]    r_ocup;

   logic                    w_vazio;
   logic                    w_pop;
   logic [LARG_OCUP:0]      w_livres;
   logic                    w_push_mem;
   logic                    w_push_alu;
   logic [1:0]              w_npush;
   logic [LARG_PTR-1:0]     w_wp_alu;
   logic [31:0]             w_dado_mem;

   function automatic logic [31:0] f_formata(input logic [31:0] d,
                                             input logic [2:0]  f);
      case (f)
         3'b000:  return {{24{d[7]}}, d[7:0]};
         3'b001:  return {{16{d[15]}}, d[15:0]};
         3'b100:  return {24'd0, d[7:0]};
         3'b101:  return {16'd0, d[15:0]};
         default: return d;
      endcase
   endfunction

   assign w_vazio  = (r_ocup == '0);
   assign w_pop    = ~w_vazio;
   // Slots free once this cycle's head has been written to the bank
   assign w_livres = P_EXT - {1'b0, r_ocup}
                   + {{LARG_OCUP{1'b0}}, ~w_vazio};

   assign mem_pronto = (w_livres != '0);
   assign alu_pronto = mem_valido ? (w_livres >= (LARG_OCUP+1)'(2))
                                  : (w_livres != '0);

   assign w_push_mem = mem_valido & mem_pronto & (mem_rd != 5'd0);
   assign w_push_alu = alu_valido & alu_pronto & (alu_rd != 5'd0);
   assign w_npush    = {1'b0, w_push_mem} + {1'b0, w_push_alu};
   assign w_wp_alu   = w_push_mem ? r_wp + LARG_PTR'(1) : r_wp;
   assign w_dado_mem = f_formata(mem_dado, mem_funct3);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_rp   <= '0;
         r_wp   <= '0;
         r_ocup <= '0;
         r_val  <= '0;
         for (int i = 0; i < PROFUNDIDADE; i++) begin
            r_rd[i]   <= '0;
            r_dado[i] <= '0;
         end
      end else begin
         // Pop first so a push into the freed slot keeps its valid bit
         if (w_pop) begin
            r_val[r_rp] <= 1'b0;
            r_rp        <= r_rp + LARG_PTR'(1);
         end
         if (w_push_mem) begin
            r_rd[r_wp]   <= mem_rd;
            r_dado[r_wp] <= w_dado_mem;
            r_val[r_wp]  <= 1'b1;
         end
         if (w_push_alu) begin
            r_rd[w_wp_alu]   <= alu_rd;
            r_dado[w_wp_alu] <= alu_dado;
            r_val[w_wp_alu]  <= 1'b1;
         end
         r_wp   <= r_wp + LARG_PTR'(w_npush);
         r_ocup <= r_ocup + LARG_OCUP'(w_npush)
                 - LARG_OCUP'(w_pop);
      end
   end

   assign reg_escrita   = ~w_vazio;
   assign endereco_regd = w_vazio ? 5'd0  : r_rd[r_rp];
   assign dado_escrita  = w_vazio ? 32'd0 : r_dado[r_rp];
   assign ocupacao      = r_ocup;
   assign vazio         = w_vazio;

`ifdef ESCRITA_ENCAMINHAMENTO_EN
   logic [31:0] w_fwd1;
   logic [31:0] w_fwd2;
   assign dado_encaminhado1 = w_fwd1;
   assign dado_encaminhado2 = w_fwd2;
`endif

   // Scan oldest to youngest so the last match is the youngest
   always_comb begin
      pendente1 = 1'b0;
      pendente2 = 1'b0;
`ifdef ESCRITA_ENCAMINHAMENTO_EN
      w_fwd1 = '0;
      w_fwd2 = '0;
`endif
      for (int i = 0; i < PROFUNDIDADE; i++) begin
         logic [LARG_PTR-1:0] w_idx;
         w_idx = r_rp + LARG_PTR'(i);
         if (r_val[w_idx] && consulta_reg1 != 5'd0
             && r_rd[w_idx] == consulta_reg1) begin
            pendente1 = 1'b1;
`ifdef ESCRITA_ENCAMINHAMENTO_EN
            w_fwd1 = r_dado[w_idx];
`endif
         end
         if (r_val[w_idx] && consulta_reg2 != 5'd0
             && r_rd[w_idx] == consulta_reg2) begin
            pendente2 = 1'b1;
`ifdef ESCRITA_ENCAMINHAMENTO_EN
            w_fwd2 = r_dado[w_idx];
`endif
         end
      end
   end

endmodule

// File: tb/tb_controlador_escrita_registradores.sv
// Scoreboard bench for controlador_escrita_registradores.
// Define ESCRITA_ENCAMINHAMENTO_EN to also check the forwarding ports.
module tb_controlador_escrita_registradores;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        alu_valido = 1'b0;
   logic        alu_pronto;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_dado = '0;
   logic        mem_valido = 1'b0;
   logic        mem_pronto;
   logic [4:0]  mem_rd = '0;
   logic [31:0] mem_dado = '0;
   logic [2:0]  mem_funct3 = '0;
   logic        reg_escrita;
   logic [4:0]  endereco_regd;
   logic [31:0] dado_escrita;
   logic [4:0]  consulta_reg1 = '0;
   logic [4:0]  consulta_reg2 = '0;
   logic        pendente1;
   logic        pendente2;
   logic [2:0]  ocupacao;
   logic        vazio;
`ifdef ESCRITA_ENCAMINHAMENTO_EN
   logic [31:0] dado_encaminhado1;
   logic [31:0] dado_encaminhado2;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   ent_t sb[$];

   controlador_escrita_registradores dut (
      .clock(clock), .reset_n(reset_n),
      .alu_valido(alu_valido), .alu_pronto(alu_pronto),
      .alu_rd(alu_rd), .alu_dado(alu_dado),
      .mem_valido(mem_valido), .mem_pronto(mem_pronto),
      .mem_rd(mem_rd), .mem_dado(mem_dado),
      .mem_funct3(mem_funct3),
      .reg_escrita(reg_escrita), .endereco_regd(endereco_regd),
      .dado_escrita(dado_escrita),
      .consulta_reg1(consulta_reg1), .consulta_reg2(consulta_reg2),
      .pendente1(pendente1), .pendente2(pendente2),
      .ocupacao(ocupacao), .vazio(vazio)
`ifdef ESCRITA_ENCAMINHAMENTO_EN
      , .dado_encaminhado1(dado_encaminhado1)
      , .dado_encaminhado2(dado_encaminhado2)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] f);
      logic [31:0] r;
      r = d;
      if (f == 3'd0) r = d[7] ? (32'hFFFFFF00 | {24'd0, d[7:0]}) : {24'd0, d[7:0]};
      if (f == 3'd1) r = d[15] ? (32'hFFFF0000 | {16'd0, d[15:0]}) : {16'd0, d[15:0]};
      if (f == 3'd4) r = d & 32'h000000FF;
      if (f == 3'd5) r = d & 32'h0000FFFF;
      return r;
   endfunction

   // Reference model: queue contents equal the FIFO, so its size is the occupancy
   always @(negedge clock) begin : monitor
      int          m_ocup;
      int          livres;
      bit          e_mem, e_alu, e_p1, e_p2;
      logic [31:0] e_f1, e_f2;
      ent_t        h;
      if (mon_en) begin
         m_ocup = sb.size();
         e_p1 = 0; e_p2 = 0; e_f1 = '0; e_f2 = '0;
         foreach (sb[i]) begin
            if (consulta_reg1 != 0 && sb[i].rd == consulta_reg1) begin
               e_p1 = 1; e_f1 = sb[i].d;
            end
            if (consulta_reg2 != 0 && sb[i].rd == consulta_reg2) begin
               e_p2 = 1; e_f2 = sb[i].d;
            end
         end
         n_vec++;
         if (ocupacao !== 3'(m_ocup) || vazio !== (m_ocup == 0)) begin
            n_err++;
            $display("FAIL occupancy: got %0d/vazio=%0b want %0d", ocupacao, vazio, m_ocup);
         end
         n_vec++;
         if (pendente1 !== e_p1 || pendente2 !== e_p2) begin
            n_err++;
            $display("FAIL pending: got %0b%0b want %0b%0b", pendente1, pendente2, e_p1, e_p2);
         end
`ifdef ESCRITA_ENCAMINHAMENTO_EN
         n_vec++;
         if (dado_encaminhado1 !== e_f1 || dado_encaminhado2 !== e_f2) begin
            n_err++;
            $display("FAIL forward: got %h/%h want %h/%h", dado_encaminhado1, dado_encaminhado2, e_f1, e_f2);
         end
`endif
         n_vec++;
         if (m_ocup > 0) begin
            h = sb.pop_front();
            if (reg_escrita !== 1'b1 || endereco_regd !== h.rd || dado_escrita !== h.d) begin
               n_err++;
               $display("FAIL write: got we=%0b rd=%0d d=%h want we=1 rd=%0d d=%h",
                        reg_escrita, endereco_regd, dado_escrita, h.rd, h.d);
            end
         end else if (reg_escrita !== 1'b0 || endereco_regd !== 5'd0 || dado_escrita !== 32'd0) begin
            n_err++;
            $display("FAIL idle_write: got we=%0b rd=%0d d=%h want 0/0/0",
                     reg_escrita, endereco_regd, dado_escrita);
         end
         livres = 4 - m_ocup + ((m_ocup != 0) ? 1 : 0);
         e_mem = (livres >= 1);
         e_alu = (livres >= (mem_valido ? 2 : 1));
         n_vec++;
         if (mem_pronto !== e_mem || alu_pronto !== e_alu) begin
            n_err++;
            $display("FAIL ready: got mem=%0b alu=%0b want mem=%0b alu=%0b",
                     mem_pronto, alu_pronto, e_mem, e_alu);
         end
         if (!reset_n) sb.delete();
         else begin
            if (mem_valido && e_mem && mem_rd != 0) sb.push_back('{mem_rd, ext(mem_dado, mem_funct3)});
            if (alu_valido && e_alu && alu_rd != 0) sb.push_back('{alu_rd, alu_dado});
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      alu_valido = 0;
      mem_valido = 0;
   endtask

   task automatic test_reset();
      reset_n = 0;
      idle();
      tick();
      mon_en = 1;
      @(negedge clock);
      n_vec++;
      if (reg_escrita !== 0 || vazio !== 1 || ocupacao !== 0 || alu_pronto !== 1 || mem_pronto !== 1) begin
         n_err++;
         $display("FAIL reset: got we=%0b vazio=%0b ocup=%0d rdy=%0b%0b want 0 1 0 11",
                  reg_escrita, vazio, ocupacao, alu_pronto, mem_pronto);
      end
      tick();
      reset_n = 1;
   endtask

   task automatic test_single_alu();
      alu_valido = 1; alu_rd = 5; alu_dado = 32'h1234;
      tick();
      idle();
      @(negedge clock);
      n_vec++;
      if (reg_escrita !== 1 || endereco_regd !== 5 || dado_escrita !== 32'h1234) begin
         n_err++;
         $display("FAIL single_alu: got we=%0b rd=%0d d=%h want 1 5 00001234",
                  reg_escrita, endereco_regd, dado_escrita);
      end
      tick();
      @(negedge clock);
      n_vec++;
      if (vazio !== 1) begin
         n_err++;
         $display("FAIL single_drain: got vazio=%0b want 1", vazio);
      end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f [7] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd2, 3'd0, 3'd6};
      logic [31:0] d [7] = '{32'h000000F0, 32'hFFFFFFF0, 32'h00008001, 32'h12348001,
                             32'h80000080, 32'hABCDEF7F, 32'hABCD00F0};
      logic [31:0] e [7] = '{32'hFFFFFFF0, 32'h000000F0, 32'h00008001, 32'hFFFF8001,
                             32'h80000080, 32'h0000007F, 32'hABCD00F0};
      for (int i = 0; i < 7; i++) begin
         mem_valido = 1; mem_rd = 7; mem_funct3 = f[i]; mem_dado = d[i];
         tick();
         idle();
         @(negedge clock);
         n_vec++;
         if (reg_escrita !== 1 || endereco_regd !== 7 || dado_escrita !== e[i]) begin
            n_err++;
            $display("FAIL load_ext[%0d]: got rd=%0d d=%h want rd=7 d=%h",
                     i, endereco_regd, dado_escrita, e[i]);
         end
         tick();
      end
   endtask

   task automatic test_simul();
      mem_valido = 1; mem_rd = 3; mem_dado = 32'hA; mem_funct3 = 3'd2;
      alu_valido = 1; alu_rd = 4; alu_dado = 32'hB;
      tick();
      idle();
      @(negedge clock);
      n_vec++;
      if (endereco_regd !== 3 || dado_escrita !== 32'hA) begin
         n_err++;
         $display("FAIL simul_first: got rd=%0d d=%h want 3 0000000a", endereco_regd, dado_escrita);
      end
      tick();
      @(negedge clock);
      n_vec++;
      if (endereco_regd !== 4 || dado_escrita !== 32'hB) begin
         n_err++;
         $display("FAIL simul_second: got rd=%0d d=%h want 4 0000000b", endereco_regd, dado_escrita);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int  maxo = 0;
      bit  saw_bp = 0;
      bit  a_acc, m_acc, done;
      mem_rd = 5'($urandom_range(1, 31)); mem_dado = $urandom; mem_funct3 = 3'($urandom_range(0, 7));
      alu_rd = 5'($urandom_range(1, 31)); alu_dado = $urandom;
      for (int c = 0; c < 16; c++) begin
         mem_valido = 1; alu_valido = 1;
         @(negedge clock);
         a_acc = alu_pronto; m_acc = mem_pronto;
         if (int'(ocupacao) > maxo) maxo = int'(ocupacao);
         if (!alu_pronto && mem_valido) saw_bp = 1;
         tick();
         if (a_acc) begin
            alu_rd = 5'($urandom_range(1, 31)); alu_dado = $urandom;
         end
         if (m_acc) begin
            mem_rd = 5'($urandom_range(1, 31)); mem_dado = $urandom;
            mem_funct3 = 3'($urandom_range(0, 7));
         end
      end
      idle();
      done = 0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clock);
         if (vazio) done = 1;
         else tick();
      end
      n_vec++;
      if (maxo != 4) begin
         n_err++;
         $display("FAIL saturate: got max ocupacao %0d want 4", maxo);
      end
      n_vec++;
      if (!saw_bp) begin
         n_err++;
         $display("FAIL backpressure: got no alu stall want alu_pronto=0 when full");
      end
      n_vec++;
      if (!done || sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got vazio=%0b pending model entries %0d want 1 0", vazio, sb.size());
      end
      tick();
   endtask

   task automatic test_x0_pending();
      bit gone = 0;
      alu_valido = 1; alu_rd = 0; alu_dado = 32'hDEAD;
      @(negedge clock);
      n_vec++;
      if (alu_pronto !== 1) begin
         n_err++;
         $display("FAIL x0_ready: got %0b want 1", alu_pronto);
      end
      tick();
      idle();
      @(negedge clock);
      n_vec++;
      if (reg_escrita !== 0 || ocupacao !== 0) begin
         n_err++;
         $display("FAIL x0_write: got we=%0b ocup=%0d want 0 0", reg_escrita, ocupacao);
      end
      tick();
      consulta_reg1 = 9; consulta_reg2 = 0;
      mem_valido = 1; mem_rd = 1; mem_dado = 32'h11; mem_funct3 = 3'd2;
      alu_valido = 1; alu_rd = 2; alu_dado = 32'h22;
      tick();
      mem_rd = 3; mem_dado = 32'h33; alu_rd = 9; alu_dado = 32'h99;
      tick();
      idle();
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         n_vec++;
         if (pendente1 !== !gone || pendente2 !== 0) begin
            n_err++;
            $display("FAIL pend_rd9[%0d]: got p1=%0b p2=%0b want p1=%0b p2=0", k, pendente1, pendente2, !gone);
         end
         if (reg_escrita && endereco_regd == 9) gone = 1;
         tick();
      end
      n_vec++;
      if (!gone) begin
         n_err++;
         $display("FAIL pend_drain: got rd=9 never written want written");
      end
      mem_valido = 1; mem_rd = 9; mem_dado = 32'h1; mem_funct3 = 3'd2;
      alu_valido = 1; alu_rd = 9; alu_dado = 32'h2;
      tick();
      idle();
      @(negedge clock);
      n_vec++;
`ifdef ESCRITA_ENCAMINHAMENTO_EN
      if (pendente1 !== 1 || dado_encaminhado1 !== 32'h2) begin
         n_err++;
         $display("FAIL fwd_youngest: got p1=%0b d=%h want 1 00000002", pendente1, dado_encaminhado1);
      end
`else
      if (pendente1 !== 1) begin
         n_err++;
         $display("FAIL pend_dup: got p1=%0b want 1", pendente1);
      end
`endif
      tick();
      tick();
      consulta_reg1 = 0;
   endtask

   task automatic test_reset_inflight();
      mem_valido = 1; mem_rd = 12; mem_dado = 32'h5; mem_funct3 = 3'd2;
      alu_valido = 1; alu_rd = 13; alu_dado = 32'h6;
      tick(); tick(); tick();
      reset_n = 0;
      tick();
      reset_n = 1;
      idle();
      @(negedge clock);
      n_vec++;
      if (ocupacao !== 0 || vazio !== 1 || reg_escrita !== 0) begin
         n_err++;
         $display("FAIL reset_inflight: got ocup=%0d vazio=%0b we=%0b want 0 1 0", ocupacao, vazio, reg_escrita);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_load_ext();
      test_simul();
      test_back_to_back();
      test_x0_pending();
      test_reset_inflight();
      mon_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

endmodule
